// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: serialises instruction-fetch and data requests onto one RAM port.
// Latency: grant one cycle after the request; done in the first grant cycle the RAM reports ACCESS/ERROR.
// Backpressure: iwait/dwait stay high until completion; data has priority, with fetch starvation bounded by STARVE_LIMIT.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate
);
    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] IGNT = 2'd1;
    localparam logic [1:0] DGNT = 2'd2;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [1:0] state;
    logic [1:0] next_state;
    logic [3:0] dstreak;
    logic [3:0] next_dstreak;
    logic       d_req;
    logic       ram_done;
    logic       streak_ok;

    assign d_req     = dREN | dWEN;
    // ERROR completes the access just like ACCESS; the requester gets whatever ramload holds.
    assign ram_done  = (ramstate == RAM_ACCESS) || (ramstate == RAM_ERROR);
    assign streak_ok = (dstreak < LIMIT);

    always_comb begin
        next_state   = state;
        next_dstreak = dstreak;
        iwait        = iREN;
        dwait        = d_req;
        iload        = '0;
        dload        = '0;
        ramREN       = 1'b0;
        ramWEN       = 1'b0;
        ramaddr      = '0;
        ramstore     = '0;
        if (!RST) begin
            case (state)
                IDLE: begin
                    if (d_req && (!iREN || streak_ok)) begin
                        next_state = DGNT;
                    end else if (iREN) begin
                        next_state = IGNT;
                    end
                end
                IGNT: begin
                    // Strobe follows the live request so an abort drops it in the same cycle.
                    ramREN  = iREN;
                    ramaddr = iaddr;
                    if (!iREN) begin
                        next_state = IDLE;
                    end else if (ram_done) begin
                        iwait        = 1'b0;
                        iload        = ramload;
                        next_state   = IDLE;
                        next_dstreak = '0;
                    end
                end
                DGNT: begin
                    ramaddr  = daddr;
                    ramstore = dstore;
                    ramWEN   = dWEN;
                    ramREN   = dREN & ~dWEN;
                    if (!d_req) begin
                        next_state = IDLE;
                    end else if (ram_done) begin
                        dwait      = 1'b0;
                        dload      = ramload;
                        next_state = IDLE;
                        if (iREN) begin
                            next_dstreak = (dstreak == 4'hF) ? dstreak : dstreak + 4'd1;
                        end else begin
                            next_dstreak = '0;
                        end
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            dstreak <= '0;
        end else begin
            state   <= next_state;
            dstreak <= next_dstreak;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a latency-programmable RAM model and completion scoreboards.
module tb_mem_arbiter;
    localparam int LIMIT = 4;
    localparam logic [1:0] R_FREE = 2'd0, R_BUSY = 2'd1, R_ACCESS = 2'd2, R_ERROR = 2'd3;

    logic        CLK = 1'b0;
    logic        RST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        iwait, dwait, ramREN, ramWEN;
    logic [31:0] iload, dload, ramaddr, ramstore;

    mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    // RAM model: answers ACCESS (or ERROR) on the lat-th consecutive strobed cycle.
    logic [31:0] mem [256];
    int          lat = 1;
    logic        use_err = 1'b0;
    int          cnt = 0;
    logic        strobe;

    assign strobe = ramREN | ramWEN;

    always_comb begin
        ramstate = R_FREE;
        ramload  = 32'h0;
        if (strobe) begin
            if (cnt >= lat - 1) begin
                ramstate = use_err ? R_ERROR : R_ACCESS;
                ramload  = mem[ramaddr[9:2]];
            end else begin
                ramstate = R_BUSY;
            end
        end
    end

    always @(posedge CLK) begin
        if (strobe && ramstate == R_BUSY) cnt <= cnt + 1;
        else cnt <= 0;
        if (ramWEN && (ramstate == R_ACCESS || ramstate == R_ERROR)) mem[ramaddr[9:2]] = ramstore;
    end

    // Scoreboards
    typedef struct {
        logic        is_w;
        logic [31:0] addr;
        logic [31:0] dat;
    } dexp_t;

    logic [31:0] iq[$];
    dexp_t       dq[$];
    int          checks = 0;
    int          errors = 0;
    string       order = "";

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge CLK) begin
        logic [31:0] ie;
        dexp_t       de;
        if (iREN && !iwait) begin
            order = {order, "I"};
            chk("i_sb_pending", 32'(iq.size() != 0), 32'd1);
            if (iq.size() != 0) begin
                ie = iq.pop_front();
                chk("iload", iload, ie);
            end
        end else begin
            chk("iload_zero", iload, 32'h0);
        end
        if ((dREN || dWEN) && !dwait) begin
            order = {order, "D"};
            chk("d_sb_pending", 32'(dq.size() != 0), 32'd1);
            if (dq.size() != 0) begin
                de = dq.pop_front();
                chk("d_addr", ramaddr, de.addr);
                if (de.is_w) begin
                    chk("d_wen", 32'(ramWEN), 32'd1);
                    chk("d_store", ramstore, de.dat);
                end else begin
                    chk("dload", dload, de.dat);
                end
            end
        end else begin
            chk("dload_zero", dload, 32'h0);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Returns at the negedge of the completion cycle, or flags a timeout.
    task automatic wait_done(input bit port_d, input int maxc);
        int n;
        n = 0;
        forever begin
            @(negedge CLK);
            if (port_d ? !dwait : !iwait) break;
            n++;
            if (n >= maxc) begin
                chk(port_d ? "d_done_budget" : "i_done_budget", 32'(port_d ? dwait : iwait), 32'd0);
                break;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 | (i << 2);
        mem[16] = 32'h8C01_0004;
        RST = 1'b1; iREN = 1'b1; dREN = 1'b1; dWEN = 1'b0;
        iaddr = 32'h0; daddr = 32'h0; dstore = 32'h0;

        // Reset outputs
        tick(); #1;
        chk("rst_iwait", 32'(iwait), 32'd1);
        chk("rst_dwait", 32'(dwait), 32'd1);
        chk("rst_strobes", 32'({ramREN, ramWEN}), 32'd0);
        chk("rst_ramaddr", ramaddr, 32'h0);
        chk("rst_state", 32'(dut.state), 32'd0);
        chk("rst_dstreak", 32'(dut.dstreak), 32'd0);
        iREN = 1'b0; dREN = 1'b0;
        tick(); RST = 1'b0;

        // Single fetch, RAM answers on the first strobed cycle
        tick(); iREN = 1'b1; iaddr = 32'h40; iq.push_back(32'h8C01_0004);
        #1 chk("f_req_iwait", 32'(iwait), 32'd1);
        chk("f_req_noreq", 32'(ramREN), 32'd0);
        tick(); #1;
        chk("f_ramren", 32'(ramREN), 32'd1);
        chk("f_ramaddr", ramaddr, 32'h40);
        chk("f_iwait_low", 32'(iwait), 32'd0);
        tick(); iREN = 1'b0; #1;
        chk("f_idle", 32'(dut.state), 32'd0);
        chk("f_idle_strobe", 32'(ramREN), 32'd0);

        // Write wins over a simultaneous fetch
        lat = 2;
        tick(); iREN = 1'b1; iaddr = 32'h44; dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEAD_BEEF;
        dq.push_back('{1'b1, 32'h100, 32'hDEAD_BEEF});
        iq.push_back(32'h1000_0044);
        tick(); #1;
        chk("w_ramwen", 32'(ramWEN), 32'd1);
        chk("w_ramren", 32'(ramREN), 32'd0);
        chk("w_ramaddr", ramaddr, 32'h100);
        chk("w_iwait", 32'(iwait), 32'd1);
        chk("w_dwait_busy", 32'(dwait), 32'd1);
        wait_done(1'b1, 4);
        tick(); dWEN = 1'b0; #1;
        chk("w_gap_idle", 32'(dut.state), 32'd0);
        chk("w_gap_iwait", 32'(iwait), 32'd1);
        chk("w_gap_dstreak", 32'(dut.dstreak), 32'd1);
        tick(); #1;
        chk("w_then_ignt", 32'(dut.state), 32'd1);
        chk("w_then_addr", ramaddr, 32'h44);
        wait_done(1'b0, 4);
        tick(); iREN = 1'b0;

        // Starvation bound with both ports continuously requesting
        order = "";
        iREN = 1'b1; iaddr = 32'h48; dREN = 1'b1; daddr = 32'h100;
        for (int k = 0; k < 8; k++) dq.push_back('{1'b0, 32'h100, 32'hDEAD_BEEF});
        iq.push_back(32'h1000_0048);
        iq.push_back(32'h1000_0048);
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (c == 12) begin
                #1 chk("s_streak_limit", 32'(dut.dstreak), 32'(LIMIT));
                chk("s_idle_before_fetch", 32'(dut.state), 32'd0);
            end
        end
        iREN = 1'b0; dREN = 1'b0;
        checks++;
        assert (order == "DDDDIDDDDI") else begin
            errors++;
            $error("FAIL starve_order: observed %s expected DDDDIDDDDI", order);
        end

        // RAM latency: BUSY for three cycles, ACCESS on the fourth grant cycle
        lat = 4;
        tick(); iREN = 1'b1; iaddr = 32'h4C; iq.push_back(32'h1000_004C);
        #1 chk("l_req_iwait", 32'(iwait), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            tick(); #1;
            chk("l_ramaddr", ramaddr, 32'h4C);
            chk("l_iwait", 32'(iwait), 32'(k < 4));
        end
        tick(); iREN = 1'b0;

        // Data abort in the second grant cycle with a fetch pending
        tick(); dREN = 1'b1; daddr = 32'h100; iREN = 1'b1; iaddr = 32'h50;
        iq.push_back(32'h1000_0050);
        tick(); #1;
        chk("a_dgnt", 32'(dut.state), 32'd2);
        chk("a_ramren", 32'(ramREN), 32'd1);
        tick(); dREN = 1'b0; #1;
        chk("a_strobe_drop", 32'(ramREN), 32'd0);
        chk("a_iwait", 32'(iwait), 32'd1);
        tick(); #1;
        chk("a_idle", 32'(dut.state), 32'd0);
        tick(); #1;
        chk("a_fetch_ignt", 32'(dut.state), 32'd1);
        chk("a_fetch_addr", ramaddr, 32'h50);
        wait_done(1'b0, 8);
        tick(); iREN = 1'b0;

        // Reset during a fetch grant while the RAM is busy
        lat = 2;
        tick(); dREN = 1'b1; daddr = 32'h100; iREN = 1'b1; iaddr = 32'h54;
        dq.push_back('{1'b0, 32'h100, 32'hDEAD_BEEF});
        iq.push_back(32'h1000_0054);
        wait_done(1'b1, 6);
        tick(); dREN = 1'b0; lat = 4; #1;
        chk("r_streak_before", 32'(dut.dstreak), 32'd1);
        tick(); #1;
        chk("r_ignt", 32'(dut.state), 32'd1);
        chk("r_ramren", 32'(ramREN), 32'd1);
        tick(); RST = 1'b1;
        tick(); RST = 1'b0; #1;
        chk("r_idle", 32'(dut.state), 32'd0);
        chk("r_strobe", 32'({ramREN, ramWEN}), 32'd0);
        chk("r_dstreak", 32'(dut.dstreak), 32'd0);
        chk("r_iwait", 32'(iwait), 32'd1);
        tick(); #1;
        chk("r_resume", 32'(dut.state), 32'd1);
        wait_done(1'b0, 8);
        tick(); iREN = 1'b0;

        // ERROR completes like ACCESS
        lat = 1; use_err = 1'b1;
        tick(); dREN = 1'b1; daddr = 32'h100;
        dq.push_back('{1'b0, 32'h100, 32'hDEAD_BEEF});
        wait_done(1'b1, 4);
        tick(); dREN = 1'b0; use_err = 1'b0; #1;
        chk("e_idle", 32'(dut.state), 32'd0);

        tick(); tick();
        chk("i_sb_drained", 32'(iq.size()), 32'd0);
        chk("d_sb_drained", 32'(dq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
